// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types and constants for the pipeline sequencing
//                controller and decode-side hazard logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Sequencer states: post-reset clear, normal issue, mul/div in flight
    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_MD_BUSY = 2'd2
    } hscState_t;

    // Architectural zero register; a write to it never creates a dependency
    localparam logic [4:0] C_REG_X0 = 5'd0;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational load-use dependency check between the load in
//                EX and the source operands of the instruction in ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       i_memRead,
    input  logic [4:0] i_rdAddr,
    input  logic [4:0] i_rs1Addr,
    input  logic [4:0] i_rs2Addr,
    input  logic       i_rs1Used,
    input  logic       i_rs2Used,
    output logic       o_loadUse
);

    logic w_rs1Hit;
    logic w_rs2Hit;

    // Only operands the ID instruction really reads can depend on the load
    always_comb begin
        w_rs1Hit  = i_rs1Used && (i_rs1Addr == i_rdAddr);
        w_rs2Hit  = i_rs2Used && (i_rs2Addr == i_rdAddr);
        o_loadUse = i_memRead && (i_rdAddr != C_REG_X0) && (w_rs1Hit || w_rs2Hit);
    end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_ctrl
//  Description : Pipeline sequencing controller for the 5-stage core. Drives
//                PC / pipeline-register enables and bubble flushes for
//                load-use, taken branches, data-memory waits and multi-cycle
//                mul/div operations, with a mul/div watchdog.
//                Optional: define HSC_PERF_CNT_EN to add stall/flush counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MemRead_ex,
    input  logic [4:0]       rdAddr_ex,
    input  logic [4:0]       rs1Addr_id,
    input  logic [4:0]       rs2Addr_id,
    input  logic             rs1Used_id,
    input  logic             rs2Used_id,
    input  logic             BranchTaken_ex,
    input  logic             MdOp_ex,
    input  logic             md_done,
    input  logic             MemReq_mem,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             md_start,
`ifdef HSC_PERF_CNT_EN
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`else
    output logic             md_timeout
`endif
);

    localparam int c_wdogW = $clog2(MD_TIMEOUT) + 1;

    hscState_t          r_state;
    hscState_t          w_nextState;
    logic               r_mdDoneQ;
    logic [c_wdogW-1:0] r_wdog;

    logic w_memStall;
    logic w_loadUse;
    logic w_wdogExpire;
    logic w_mdDoneAny;
    logic w_release;
    logic w_mdEnter;

    hazard_detect u_hazardDetect (
        .i_memRead (MemRead_ex),
        .i_rdAddr  (rdAddr_ex),
        .i_rs1Addr (rs1Addr_id),
        .i_rs2Addr (rs2Addr_id),
        .i_rs1Used (rs1Used_id),
        .i_rs2Used (rs2Used_id),
        .o_loadUse (w_loadUse)
    );

    // Shared qualifiers for the state machine, watchdog and output decode
    always_comb begin
        w_memStall   = MemReq_mem && !dmem_ready;
        w_wdogExpire = (r_wdog == c_wdogW'(MD_TIMEOUT - 1));
        w_mdDoneAny  = md_done || r_mdDoneQ;
        w_release    = (w_mdDoneAny || w_wdogExpire) && !w_memStall;
        w_mdEnter    = (r_state == ST_RUN) && !w_memStall && !BranchTaken_ex && MdOp_ex;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state: one clear cycle after reset, then RUN <-> MD_BUSY
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_INIT:    w_nextState = ST_RUN;
            ST_RUN:     if (w_mdEnter) w_nextState = ST_MD_BUSY;
            ST_MD_BUSY: if (w_release) w_nextState = ST_RUN;
            default:    w_nextState = ST_INIT;
        endcase
    end

    // Watchdog and done latch; both hold across memory stalls except done capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mdDoneQ <= 1'b0;
            r_wdog    <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mdEnter) begin
                        r_mdDoneQ <= 1'b0;
                        r_wdog    <= '0;
                    end
                end
                ST_MD_BUSY: begin
                    if (w_release) begin
                        r_mdDoneQ <= 1'b0;
                        r_wdog    <= '0;
                    end else begin
                        r_mdDoneQ <= r_mdDoneQ | md_done;
                        if (!w_memStall) begin
                            r_wdog <= r_wdog + c_wdogW'(1);
                        end
                    end
                end
                default: begin
                    r_mdDoneQ <= 1'b0;
                    r_wdog    <= '0;
                end
            endcase
        end
    end

    // Output decode in priority order: mem stall, mul/div busy, branch, md issue, load-use
    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        md_start     = 1'b0;
        md_timeout   = 1'b0;
        if ((r_state != ST_RUN) && (r_state != ST_MD_BUSY)) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
        end else if (w_memStall) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
        end else if (r_state == ST_MD_BUSY) begin
            if (!w_release) begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Write  = 1'b0;
                EX_MEM_Flush = 1'b1;
            end else begin
                md_timeout = w_wdogExpire && !w_mdDoneAny;
            end
        end else if (BranchTaken_ex) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (MdOp_ex) begin
            md_start     = 1'b1;
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Flush = 1'b1;
        end else if (w_loadUse) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end
    end

`ifdef HSC_PERF_CNT_EN
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    // Stall cycles (PC held) and branch-flush cycles outside the reset clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else if (r_state != ST_INIT) begin
            if (!PCWrite) begin
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            end
            if (IF_ID_Flush) begin
                r_flushCnt <= r_flushCnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stallCnt;
    assign flush_cnt = r_flushCnt;
`else
    localparam int c_cntWidthUnused = CNT_W;
`endif

endmodule : hazard_stall_ctrl
`default_nettype wire
